// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It handles three cases: load-use bubbles, branch flushes resolved in MEM,
// and multi-cycle data-memory waits. A wait timeout halts the core, and a
// saturating counter records the cycles in which the PC is held.
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_bc,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             dmem_ready,
    input  logic             clr_stats,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             id_ex_enable,
    output logic             ex_mem_enable,
    output logic             mem_wb_enable,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_sel_branch,
    output logic             dmem_req,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_error
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        LOAD_STALL = 3'd1,
        MEM_WAIT   = 3'd2,
        FLUSH      = 3'd3,
        HALT       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              mem_error_q, mem_error_d;
    logic              load_use;
    logic              mem_stall;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign mem_stall   = dmem_req && !dmem_ready;
    assign state_o     = state_q;
    assign stall_count = stall_cnt_q;
    assign mem_error   = mem_error_q;

    // Next-state and control outputs: memory stall beats branch, which beats load-use.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        mem_error_d   = mem_error_q;
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        pc_sel_branch = 1'b0;
        dmem_req      = (mem_mem_read || mem_mem_write) && (state_q != HALT);

        if (!reset) begin
            // Reset owns the pipeline: nothing advances and no request goes out.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            dmem_req      = 1'b0;
            state_d       = RUN;
        end else if (state_q == HALT) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
        end else if (mem_stall) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            if (state_q == MEM_WAIT) begin
                if (wait_cnt_q == WC_W'(MAX_WAIT)) begin
                    state_d     = HALT;
                    mem_error_d = 1'b1;
                end else begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end else begin
                state_d    = MEM_WAIT;
                wait_cnt_d = WC_W'(1);
            end
        end else if (mem_bc && (state_q != FLUSH)) begin
            // The instructions in IF, ID and EX are on the wrong path.
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            state_d       = FLUSH;
        end else if (load_use && (state_q != LOAD_STALL)) begin
            // Hold IF and ID for one cycle and insert a bubble into EX.
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
            state_d      = LOAD_STALL;
        end else begin
            state_d = RUN;
        end
    end

    // Saturating count of PC-hold cycles; a clear request wins over the increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_stats)
            stall_cnt_d = '0;
        else if (!pc_enable && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

endmodule
